dmem_arbiter: RTL

Two-port arbiter and access sequencer for the byte-addressed, synchronous MIPS data memory. It shares the memory between requester 0 (CPU load/store stage) and requester 1 (secondary master: debug/DMA). It grants in round-robin order, drives the memory strobes for exactly one clock per access, captures the registered read data, and returns it with a single-cycle acknowledge. Misaligned word accesses are rejected without touching memory.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing a synchronous byte-addressed data
// memory between two requesters; misaligned word accesses are acknowledged with err.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t            state;
   logic              last_grant;   // doubles as the id of the port being served
   logic              gnt_we;
   logic              misaligned;

   logic              sel_port;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_aligned;

   // Grant choice: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      sel_port = 1'b0;
      if (req0 && req1) begin
         sel_port = ~last_grant;
      end else if (req1) begin
         sel_port = 1'b1;
      end else begin
         sel_port = 1'b0;
      end
      sel_we      = sel_port ? we1    : we0;
      sel_addr    = sel_port ? addr1  : addr0;
      sel_wdata   = sel_port ? wdata1 : wdata0;
      sel_aligned = (sel_addr[1:0] == 2'b00);
   end

   // Access sequencer: IDLE grants, ISSUE holds the strobes, CAPTURE acknowledges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_we     <= 1'b0;
         misaligned <= 1'b0;
         mem_addr   <= {ADDR_W{1'b0}};
         mem_wdata  <= {DATA_W{1'b0}};
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= {DATA_W{1'b0}};
         rdata1     <= {DATA_W{1'b0}};
         busy       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  last_grant <= sel_port;
                  gnt_we     <= sel_we;
                  misaligned <= ~sel_aligned;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_read   <= ~sel_we & sel_aligned;
                  mem_write  <= sel_we & sel_aligned;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state     <= CAPTURE;
            end
            CAPTURE: begin
               if (last_grant) begin
                  ack1 <= 1'b1;
                  err1 <= misaligned;
                  if (!gnt_we && !misaligned) begin
                     rdata1 <= mem_rdata;
                  end else begin
                     rdata1 <= rdata1;
                  end
               end else begin
                  ack0 <= 1'b1;
                  err0 <= misaligned;
                  if (!gnt_we && !misaligned) begin
                     rdata0 <= mem_rdata;
                  end else begin
                     rdata0 <= rdata0;
                  end
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
